// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage in front of the control unit.
// Holds the 16-bit PC, drives the ROM address, latches opcode (IR) and
// operand (D), and applies PL/PH jumps with a one-instruction delay slot.
// A ROM-ready input (ROM_VALID) stalls fetch. A jump that executes during a
// stall is remembered in TGT and applied when the delay slot is fetched.
//
// Optional build macro: FETCH_STEP_EN
//   defined   -> extra STEP input, a fetch is accepted only when ROM_VALID & STEP
//   undefined -> no STEP port, a fetch is accepted whenever ROM_VALID
//
// Handshake: ROM_VALID is a ready/valid pair on the ROM side. ROM_ADDR is the
// request and is held stable while ROM_VALID is low. The word on ROM_DATA is
// consumed on the rising edge where the accept condition is high, and never
// on any other edge.
//
// The PEND output shows the FSM state: 0 = RUN, 1 = PENDING.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [7:0]  NOP_OP   = 8'h02
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        PL,
    input  logic        PH,
    input  logic [7:0]  BUS,
    input  logic [7:0]  Y,
    output logic [15:0] ROM_ADDR,
    input  logic [15:0] ROM_DATA,
    input  logic        ROM_VALID,
`ifdef FETCH_STEP_EN
    input  logic        STEP,
`endif
    output logic [7:0]  IR,
    output logic [7:0]  D,
    output logic        EXEC,
    output logic        PEND
);

    typedef enum logic {
        S_RUN     = 1'b0,
        S_PENDING = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [15:0] r_pc;
    logic [15:0] r_tgt;
    logic [7:0]  r_ir;
    logic [7:0]  r_d;
    logic        r_exec;

    logic        w_accept;
    logic        w_redirect;
    logic [15:0] w_target;
    logic        w_use_tgt;
    logic [15:0] w_pc_next;

    // Accept condition: ROM word present (and STEP pulse, when stepping is built in)
`ifdef FETCH_STEP_EN
    assign w_accept = ROM_VALID & STEP;
`else
    assign w_accept = ROM_VALID;
`endif

    // Jumps are honoured only while a real instruction is executing.
    // The near page comes from the current PC, which is the delay-slot address.
    assign w_redirect = r_exec & (PL | PH);
    assign w_target   = {(PH ? Y : r_pc[15:8]), BUS};

    // FSM state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state: enter PENDING on a stalled jump, leave on the next accept
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_RUN: begin
                if (w_redirect && !w_accept) begin
                    w_next_state = S_PENDING;
                end
            end
            S_PENDING: begin
                if (w_accept) begin
                    w_next_state = S_RUN;
                end
            end
            default: w_next_state = S_RUN;
        endcase
    end

    // FSM outputs: state flag and whether the stored target feeds the PC
    always_comb begin
        PEND      = 1'b0;
        w_use_tgt = 1'b0;
        if (r_state == S_PENDING) begin
            PEND      = 1'b1;
            w_use_tgt = 1'b1;
        end
    end

    // Next PC on an accepted fetch: the live jump wins, then the stored target,
    // otherwise sequential. 0xFFFF wraps to 0x0000 naturally.
    always_comb begin
        w_pc_next = r_pc + 16'd1;
        if (w_redirect) begin
            w_pc_next = w_target;
        end else if (w_use_tgt) begin
            w_pc_next = r_tgt;
        end
    end

    // Datapath registers: PC, stored target, IR/D and the EXEC flag
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pc   <= RESET_PC;
            r_tgt  <= 16'h0000;
            r_ir   <= NOP_OP;
            r_d    <= 8'h00;
            r_exec <= 1'b0;
        end else if (w_accept) begin
            r_pc   <= w_pc_next;
            r_ir   <= ROM_DATA[7:0];
            r_d    <= ROM_DATA[15:8];
            r_exec <= 1'b1;
        end else begin
            // Bubble: IR/D hold but are not executed again.
            r_exec <= 1'b0;
            if (w_redirect) begin
                r_tgt <= w_target;
            end
        end
    end

    assign ROM_ADDR = r_pc;
    assign IR       = r_ir;
    assign D        = r_d;
    assign EXEC     = r_exec;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed test of fetch_unit with hand-computed expectations.
// The ROM model returns opcode = 8'h02 ^ addr[15:8] and operand = addr[7:0].
// For page 0 this is opcode 02 with operand n, and IR varies on higher pages.
// Inputs change on the falling edge and outputs are checked on the falling edge.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        pl;
    logic        ph;
    logic [7:0]  bus;
    logic [7:0]  y;
    logic [15:0] rom_addr;
    logic [15:0] rom_data;
    logic        rom_valid;
`ifdef FETCH_STEP_EN
    logic        step;
`endif
    logic [7:0]  ir;
    logic [7:0]  d;
    logic        exec_o;
    logic        pend;

    int n_total;
    int n_bad;

    fetch_unit #(
        .RESET_PC (16'h0000),
        .NOP_OP   (8'h02)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .PL        (pl),
        .PH        (ph),
        .BUS       (bus),
        .Y         (y),
        .ROM_ADDR  (rom_addr),
        .ROM_DATA  (rom_data),
        .ROM_VALID (rom_valid),
`ifdef FETCH_STEP_EN
        .STEP      (step),
`endif
        .IR        (ir),
        .D         (d),
        .EXEC      (exec_o),
        .PEND      (pend)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Zero-wait ROM model
    assign rom_data = {rom_addr[7:0], rom_addr[15:8] ^ 8'h02};

    // ---------------- driver / checker tasks ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [15:0] e_addr,
                               input logic [7:0] e_ir, input logic [7:0] e_d,
                               input logic e_exec, input logic e_pend);
        check_val({tag, ".addr"}, 32'(rom_addr), 32'(e_addr));
        check_val({tag, ".ir"},   32'(ir),       32'(e_ir));
        check_val({tag, ".d"},    32'(d),        32'(e_d));
        check_val({tag, ".exec"}, 32'(exec_o),   32'(e_exec));
        check_val({tag, ".pend"}, 32'(pend),     32'(e_pend));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_total   = 0;
        n_bad     = 0;
        rst       = 1'b1;
        pl        = 1'b0;
        ph        = 1'b0;
        bus       = 8'h00;
        y         = 8'h00;
        rom_valid = 1'b0;
`ifdef FETCH_STEP_EN
        step      = 1'b1;
`endif
        tick();
        check_state("reset", 16'h0000, 8'h02, 8'h00, 1'b0, 1'b0);

        // Linear fetch up to the jump at 0x0010 (now executing, PC=0x0011)
        rst       = 1'b0;
        rom_valid = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            tick();
            check_val("lin.addr", 32'(rom_addr), 32'(i));
            check_val("lin.d",    32'(d),        32'(i - 1));
            check_val("lin.exec", 32'(exec_o),   32'd1);
        end

        // Near branch at 0x0010 to 0x40: delay slot 0x0011 fetched, then 0x0040
        pl = 1'b1; bus = 8'h40;
        tick();
        pl = 1'b0;
        check_state("near1", 16'h0040, 8'h02, 8'h11, 1'b1, 1'b0);

        // Near branch from 0x0040 to 0x00FF
        pl = 1'b1; bus = 8'hFF;
        tick();
        pl = 1'b0;
        check_state("near2", 16'h00FF, 8'h02, 8'h40, 1'b1, 1'b0);
        tick();
        check_state("fetchff", 16'h0100, 8'h02, 8'hFF, 1'b1, 1'b0);

        // Branch at 0x00FF: delay slot is 0x0100, so the target lands in page 0x01
        pl = 1'b1; bus = 8'h40;
        tick();
        pl = 1'b0;
        check_state("nearpage", 16'h0140, 8'h03, 8'h00, 1'b1, 1'b0);
        tick();
        check_state("fetch140", 16'h0141, 8'h03, 8'h40, 1'b1, 1'b0);

        // Far jump to 0x0200
        pl = 1'b1; ph = 1'b1; y = 8'h02; bus = 8'h00;
        tick();
        pl = 1'b0; ph = 1'b0;
        check_state("far0", 16'h0200, 8'h03, 8'h41, 1'b1, 1'b0);
        tick();
        check_state("fetch200", 16'h0201, 8'h00, 8'h00, 1'b1, 1'b0);

        // Far jump executing at 0x0200 -> delay slot 0x0201, then 0x1234
        pl = 1'b1; ph = 1'b1; y = 8'h12; bus = 8'h34;
        tick();
        pl = 1'b0; ph = 1'b0;
        check_state("far1", 16'h1234, 8'h00, 8'h01, 1'b1, 1'b0);
        tick();
        check_state("fetch1234", 16'h1235, 8'h10, 8'h34, 1'b1, 1'b0);

        // Jump at 0x1234 executes as ROM stalls: target 0x1280 is held pending
        pl = 1'b1; bus = 8'h80; rom_valid = 1'b0;
        tick();
        check_state("stall1", 16'h1235, 8'h10, 8'h34, 1'b0, 1'b1);
        // PL with a different BUS during the bubble must be ignored
        bus = 8'h99;
        tick();
        check_state("stall2", 16'h1235, 8'h10, 8'h34, 1'b0, 1'b1);
        pl = 1'b0;
        tick();
        check_state("stall3", 16'h1235, 8'h10, 8'h34, 1'b0, 1'b1);
        rom_valid = 1'b1;
        tick();
        check_state("unstall", 16'h1280, 8'h10, 8'h35, 1'b1, 1'b0);

        // Far jump to 0xFFFE, then run linearly across the wrap
        pl = 1'b1; ph = 1'b1; y = 8'hFF; bus = 8'hFE;
        tick();
        pl = 1'b0; ph = 1'b0;
        check_state("farff", 16'hFFFE, 8'h10, 8'h80, 1'b1, 1'b0);
        tick();
        check_state("fetchfffe", 16'hFFFF, 8'hFD, 8'hFE, 1'b1, 1'b0);
        tick();
        check_state("wrap", 16'h0000, 8'hFD, 8'hFF, 1'b1, 1'b0);

        // Stalled jump (pending), then reset overrides it
        pl = 1'b1; bus = 8'h55; rom_valid = 1'b0;
        tick();
        pl = 1'b0;
        check_state("pendpre", 16'h0000, 8'hFD, 8'hFF, 1'b0, 1'b1);
        rst = 1'b1;
        tick();
        check_state("rstpend", 16'h0000, 8'h02, 8'h00, 1'b0, 1'b0);
        rst = 1'b0; rom_valid = 1'b1;
        tick();
        // Stale target 0x0055 must be gone: sequential fetch resumes
        check_state("postrst", 16'h0001, 8'h02, 8'h00, 1'b1, 1'b0);

`ifdef FETCH_STEP_EN
        // STEP low: frozen even though ROM_VALID is high
        step = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_state("stepoff", 16'h0001, 8'h02, 8'h00, 1'b0, 1'b0);
        end
        step = 1'b1;
        tick();
        step = 1'b0;
        check_state("steppulse", 16'h0002, 8'h02, 8'h01, 1'b1, 1'b0);
        tick();
        check_state("stepafter", 16'h0002, 8'h02, 8'h01, 1'b0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the control unit.
- Holds the 16-bit program counter and drives the ROM address.
- Latches the fetched opcode into IR and the operand into D; the control unit decodes IR.
- Consumes the control unit's PL/PH jump strobes, implementing the one-instruction branch delay slot, near (in-page) branches and far jumps. Adds a ROM-ready handshake so slow program memory stalls the core cleanly.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_OP, 8'h02, opcode placed in IR on reset (ld ac; no side effects).

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- PL  input  1  from CU: load PC low byte from BUS (branch taken).
- PH  input  1  from CU: load PC high byte from Y (far jump).
- BUS  input  8  datapath bus value (jump target low byte).
- Y  input  8  Y register (far jump page).
- ROM_ADDR  output  16  program ROM address, equal to PC.
- ROM_DATA  input  16  ROM word: [7:0] = opcode, [15:8] = operand.
- ROM_VALID  input  1  ROM_DATA is valid for the current ROM_ADDR this cycle.
- IR  output  8  instruction register (to CU).
- D  output  8  operand register (to datapath/CU).
- EXEC  output  1  IR/D hold a fetched, not-yet-executed instruction; datapath commits state only when high.

Behaviour:
- Reset (RST high at an edge):
  - PC=RESET_PC, IR=NOP_OP, D=8'h00, EXEC=0, PEND=0, TGT=16'h0000.
  - Reset overrides all other inputs, including mid-stall and mid-pending.
- ROM_ADDR = PC, combinational.
- accept = ROM_VALID (with STEP_EN: ROM_VALID & STEP).
- redirect = EXEC & (PL | PH). PL/PH are ignored while EXEC=0.
- target = {PH ? Y : PC[15:8], BUS}.
  - Near branch uses the page of the current PC, i.e. the delay-slot address: a branch at 0x00FF lands in page 0x01.
- On each edge, when not in reset:
  - IR/D/EXEC:
    - accept: IR<=ROM_DATA[7:0], D<=ROM_DATA[15:8], EXEC<=1.
    - no accept: IR/D hold, EXEC<=0 (bubble; the held instruction is not re-executed).
  - PC when accept:
    - redirect: PC<=target.
    - else PEND: PC<=TGT.
    - else: PC<=PC+1.
    - PEND<=0 in all accept cases.
  - PC when no accept:
    - PC holds.
    - If redirect: PEND<=1, TGT<=target. The delay slot is not yet fetched; the target is remembered.
- States:
  - RUN (PEND=0): RUN→PENDING on redirect & !accept.
  - PENDING (PEND=1): PENDING→RUN on accept.
  - redirect cannot occur in PENDING, since EXEC=0 there.
- Delay slot:
  - Exactly one instruction, the one at jump_addr+1, always executes after a jump, independent of stalls.
  - A jump in the delay slot is honoured normally and redirects after its own delay slot.
- Latency:
  - Fetch-to-EXEC is 1 cycle.
  - A jump executed in cycle n takes effect at the fetch in cycle n+1 (zero-wait ROM).
- Wrap-around: PC 16'hFFFF + 1 → 16'h0000. No other PC saturation.
- Throughput with ROM_VALID tied high: one instruction per cycle, EXEC constantly 1 after the first cycle out of reset.

Optional Feature:
- Macro FETCH_STEP_EN.
- Defined:
  - Extra input STEP (1 bit); accept = ROM_VALID & STEP.
  - A one-cycle STEP pulse executes exactly one instruction. Debug single-stepping from a host or button synchronizer.
- Undefined:
  - No STEP port; accept = ROM_VALID.
  - Behaviour otherwise identical.

Test Plan:
- Linear fetch: ROM_VALID=1, ROM[n]={n[7:0],8'h02} → ROM_ADDR sequence 0,1,2,3…; IR=02 with D=00,01,02 on consecutive cycles; EXEC=1 from cycle 1.
- Near branch: ROM[0x0010] = jump with PL=1, BUS=0x40 → executes 0x0011 (delay slot), then ROM_ADDR=0x0040. Repeat at 0x00FF → next fetch 0x0100 (delay), then 0x0140.
- Far jump: PL=PH=1, Y=0x12, BUS=0x34 at PC 0x0200 → fetch 0x0201, then 0x1234.
- Stall during jump: ROM_VALID=0 for 3 cycles immediately after the jump executes → PEND=1, ROM_ADDR holds at the delay-slot address, EXEC=0. On ROM_VALID=1, the delay slot is fetched and the next ROM_ADDR equals the stored target.
- Wrap and reset: PC=0xFFFF linear → next 0x0000. RST asserted while PEND=1 → PC=RESET_PC, IR=0x02, D=0, EXEC=0, PEND=0 on the next edge.
- FETCH_STEP_EN: ROM_VALID=1, STEP low for 5 cycles → PC frozen, EXEC=0. A single STEP pulse → exactly one EXEC=1 cycle, PC+1.
